// File: rtl/warp_rr_issue_arbiter_pkg.sv
// Shared definitions for the warp round-robin issue arbiter: state encoding
// and a width helper used to check the grant index width.
package warp_rr_issue_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic int clog2_f(input int value);
        int width_v;
        int span_v;
        width_v = 0;
        span_v  = 1;
        while (span_v < value) begin
            span_v  = span_v * 2;
            width_v = width_v + 1;
        end
        return width_v;
    endfunction

endpackage

// File: rtl/warp_rr_issue_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of cand at or after start,
// wrapping past NUM_REQ-1 back to index 0.
module warp_rr_issue_arbiter_rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   cand,
    input  logic [REQ_WIDTH-1:0] start,
    output logic                 found,
    output logic [NUM_REQ-1:0]   pick_oh,
    output logic [REQ_WIDTH-1:0] pick_bin
);

    localparam int DW = 2 * NUM_REQ;

    logic [DW-1:0] dbl_s;
    logic [DW-1:0] masked_s;
    int            idx_s;

    // Upper copy of cand supplies the wrapped part of the search order.
    always_comb begin
        dbl_s    = {cand, cand};
        masked_s = dbl_s & ~((DW'(1'b1) << start) - DW'(1'b1));
        found    = |cand;
        idx_s    = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            idx_s = masked_s[i] ? i : idx_s;
        end
        pick_bin = (idx_s >= NUM_REQ) ? REQ_WIDTH'(idx_s - NUM_REQ) : REQ_WIDTH'(idx_s);
        pick_oh  = found ? (NUM_REQ'(1'b1) << pick_bin) : {NUM_REQ{1'b0}};
    end

endmodule

// File: rtl/warp_rr_issue_arbiter.sv
// Round-robin issue arbiter: registers a grant, presents it with valid/ready,
// and advances priority past the winner once the handshake completes.
module warp_rr_issue_arbiter
    import warp_rr_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REQ_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   grant_oh,
    output logic [REQ_WIDTH-1:0] grant_bin,
    output logic [NUM_REQ-1:0]   ack
);

    localparam int                   MIN_WIDTH = clog2_f(NUM_REQ);
    localparam logic [REQ_WIDTH-1:0] LAST_IDX  = REQ_WIDTH'(NUM_REQ - 1);

    logic                 state_r;
    logic [REQ_WIDTH-1:0] ptr_r;
    logic                 handshake_s;
    logic [NUM_REQ-1:0]   cand_s;
    logic [REQ_WIDTH-1:0] next_ptr_s;
    logic [REQ_WIDTH-1:0] start_s;
    logic                 found_s;
    logic [NUM_REQ-1:0]   pick_oh_s;
    logic [REQ_WIDTH-1:0] pick_bin_s;

    // Handshake, ack and the search start; on a handshake the search already
    // begins one past the current winner so the next grant follows bubble-free.
    always_comb begin
        handshake_s = out_valid & out_ready;
        ack         = grant_oh & {NUM_REQ{handshake_s}};
        cand_s      = req & ~ack;
        if (grant_bin == LAST_IDX) begin
            next_ptr_s = {REQ_WIDTH{1'b0}};
        end else begin
            next_ptr_s = grant_bin + REQ_WIDTH'(1'b1);
        end
        if (handshake_s) begin
            start_s = next_ptr_s;
        end else begin
            start_s = ptr_r;
        end
    end

    warp_rr_issue_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_WIDTH(REQ_WIDTH)
    ) u_pick (
        .cand    (cand_s),
        .start   (start_s),
        .found   (found_s),
        .pick_oh (pick_oh_s),
        .pick_bin(pick_bin_s)
    );

    // Grant state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            grant_oh  <= {NUM_REQ{1'b0}};
            grant_bin <= {REQ_WIDTH{1'b0}};
            ptr_r     <= {REQ_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r   <= ST_GRANT;
                        out_valid <= 1'b1;
                        grant_oh  <= pick_oh_s;
                        grant_bin <= pick_bin_s;
                    end
                end
                ST_GRANT: begin
                    if (out_ready) begin
                        ptr_r <= next_ptr_s;
                        if (found_s) begin
                            grant_oh  <= pick_oh_s;
                            grant_bin <= pick_bin_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            out_valid <= 1'b0;
                            grant_oh  <= {NUM_REQ{1'b0}};
                            grant_bin <= {REQ_WIDTH{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    grant_oh  <= {NUM_REQ{1'b0}};
                    grant_bin <= {REQ_WIDTH{1'b0}};
                    ptr_r     <= {REQ_WIDTH{1'b0}};
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_width: assert property (@(posedge clk) REQ_WIDTH >= MIN_WIDTH);
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> $onehot(grant_oh));
    a_bin_match: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (grant_oh == (NUM_REQ'(1'b1) << grant_bin)));
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(grant_oh) && $stable(grant_bin)));
    a_bin_range: assert property (@(posedge clk) disable iff (rst)
        grant_bin <= LAST_IDX);
`endif

endmodule

// File: tb/tb_warp_rr_issue_arbiter.sv
// Bench for warp_rr_issue_arbiter: a 4-requester and a 3-requester instance
// checked every cycle against a rotation-order model, plus directed literals.
module tb_warp_rr_issue_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic [3:0] req4 = 4'b0000;
    logic       rdy4 = 1'b0;
    logic       ov4;
    logic [3:0] oh4;
    logic [1:0] bin4;
    logic [3:0] ack4;
    logic [2:0] req3 = 3'b000;
    logic       rdy3 = 1'b0;
    logic       ov3;
    logic [2:0] oh3;
    logic [1:0] bin3;
    logic [2:0] ack3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_n[2]     = '{4, 3};
    int          m_valid[2] = '{0, 0};
    int          m_bin[2]   = '{0, 0};
    int          m_ptr[2]   = '{0, 0};
    logic [31:0] m_ack[2]   = '{32'd0, 32'd0};

    warp_rr_issue_arbiter #(.NUM_REQ(4), .REQ_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .out_valid(ov4), .out_ready(rdy4),
        .grant_oh(oh4), .grant_bin(bin4), .ack(ack4)
    );

    warp_rr_issue_arbiter #(.NUM_REQ(3), .REQ_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .out_valid(ov3), .out_ready(rdy3),
        .grant_oh(oh3), .grant_bin(bin3), .ack(ack3)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester found walking start, start+1, ... modulo n.
    function automatic int first_from(input logic [31:0] c, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (c[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int u, input logic [31:0] r, input logic rdy, input logic rs);
        int w;
        logic [31:0] c;
        if (rs) begin
            m_valid[u] = 0; m_bin[u] = 0; m_ptr[u] = 0;
        end else if (m_valid[u] == 0) begin
            w = first_from(r, m_ptr[u], m_n[u]);
            if (w >= 0) begin
                m_valid[u] = 1; m_bin[u] = w;
            end
        end else if (rdy) begin
            m_ptr[u] = (m_bin[u] + 1) % m_n[u];
            c = r;
            c[m_bin[u]] = 1'b0;
            w = first_from(c, m_ptr[u], m_n[u]);
            if (w >= 0) m_bin[u] = w;
            else begin
                m_valid[u] = 0; m_bin[u] = 0;
            end
        end
    endtask

    // Compare process: outputs vs model mid-cycle, then advance the model.
    initial begin
        logic [31:0] eoh4, eoh3;
        forever begin
            @(negedge clk);
            eoh4 = (m_valid[0] != 0) ? (32'(1) << m_bin[0]) : 32'd0;
            eoh3 = (m_valid[1] != 0) ? (32'(1) << m_bin[1]) : 32'd0;
            m_ack[0] = (m_valid[0] != 0 && rdy4) ? eoh4 : 32'd0;
            m_ack[1] = (m_valid[1] != 0 && rdy3) ? eoh3 : 32'd0;
            if (chk_en) begin
                cmp("n4_valid", 32'(ov4), m_valid[0]);
                cmp("n4_oh", 32'(oh4), eoh4);
                cmp("n4_bin", 32'(bin4), m_bin[0]);
                cmp("n4_ack", 32'(ack4), m_ack[0]);
                cmp("n3_valid", 32'(ov3), m_valid[1]);
                cmp("n3_oh", 32'(oh3), eoh3);
                cmp("n3_bin", 32'(bin3), m_bin[1]);
                cmp("n3_ack", 32'(ack3), m_ack[1]);
            end
            model_step(0, 32'(req4), rdy4, rst);
            model_step(1, 32'(req3), rdy3, rst);
        end
    end

    task automatic drive(input logic r, input logic [3:0] q4, input logic d4,
                         input logic [2:0] q3, input logic d3);
        @(posedge clk);
        #2;
        rst = r; req4 = q4; rdy4 = d4; req3 = q3; rdy3 = d3;
    endtask

    task automatic lit4(input string nm, input logic v, input logic [3:0] oh,
                        input logic [1:0] bin, input logic [3:0] ak);
        @(negedge clk);
        #1;
        cmp({nm, "_valid"}, 32'(ov4), 32'(v));
        cmp({nm, "_oh"}, 32'(oh4), 32'(oh));
        cmp({nm, "_bin"}, 32'(bin4), 32'(bin));
        cmp({nm, "_ack"}, 32'(ack4), 32'(ak));
    endtask

    initial begin
        logic [3:0] q4;
        logic [2:0] q3;
        logic       r;

        drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b0);
            lit4("idle", 1'b0, 4'b0000, 2'd0, 4'b0000);
        end

        // Single requester 2: granted one cycle after request, no regrant.
        drive(1'b0, 4'b0100, 1'b1, 3'b000, 1'b0);
        lit4("single_c0", 1'b0, 4'b0000, 2'd0, 4'b0000);
        drive(1'b0, 4'b0100, 1'b1, 3'b000, 1'b0);
        lit4("single_c1", 1'b1, 4'b0100, 2'd2, 4'b0100);
        drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b0);
        lit4("single_c2", 1'b0, 4'b0000, 2'd0, 4'b0000);
        drive(1'b0, 4'b1111, 1'b0, 3'b000, 1'b0);
        lit4("ptr3_wait", 1'b0, 4'b0000, 2'd0, 4'b0000);
        drive(1'b0, 4'b1111, 1'b0, 3'b000, 1'b0);
        lit4("ptr3_grant", 1'b1, 4'b1000, 2'd3, 4'b0000);

        // Full rotation from 3; reset lands on the bin=2 handshake cycle.
        for (int i = 0; i < 8; i++) begin
            drive((i == 7) ? 1'b1 : 1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
            lit4("rotate", 1'b1, 4'(1 << ((3 + i) % 4)), 2'((3 + i) % 4), 4'(1 << ((3 + i) % 4)));
        end
        drive(1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
        lit4("rst_mid", 1'b0, 4'b0000, 2'd0, 4'b0000);
        drive(1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
        lit4("rst_after", 1'b1, 4'b0001, 2'd0, 4'b0001);

        // Backpressure with illegal withdrawal of the granted request.
        drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
        drive(1'b0, 4'b0011, 1'b0, 3'b000, 1'b0);
        lit4("bp_c0", 1'b0, 4'b0000, 2'd0, 4'b0000);
        drive(1'b0, 4'b0011, 1'b0, 3'b000, 1'b0);
        lit4("bp_c1", 1'b1, 4'b0001, 2'd0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0010, 1'b0, 3'b000, 1'b0);
            lit4("bp_hold", 1'b1, 4'b0001, 2'd0, 4'b0000);
        end
        drive(1'b0, 4'b0010, 1'b1, 3'b000, 1'b0);
        lit4("bp_ack", 1'b1, 4'b0001, 2'd0, 4'b0001);
        drive(1'b0, 4'b0010, 1'b1, 3'b000, 1'b0);
        lit4("bp_next", 1'b1, 4'b0010, 2'd1, 4'b0010);
        drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b0);
        lit4("bp_drain", 1'b0, 4'b0000, 2'd0, 4'b0000);

        // Three requesters: wrap goes 2 -> 0, never 3.
        drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 4'b0000, 1'b0, 3'b111, 1'b1);
            @(negedge clk);
            #1;
            cmp("n3_wrap_valid", 32'(ov3), (i == 0) ? 32'd0 : 32'd1);
            cmp("n3_wrap_bin", 32'(bin3), (i == 0) ? 32'd0 : 32'((i - 1) % 3));
        end

        // Random traffic: pending requests held until acked.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            q4 = (req4 & ~m_ack[0][3:0]) | (4'($urandom) & 4'($urandom));
            q3 = (req3 & ~m_ack[1][2:0]) | (3'($urandom) & 3'($urandom));
            drive(r, q4, ($urandom_range(0, 9) < 7), q3, ($urandom_range(0, 9) < 7));
            @(negedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
